// File: rtl/writeback_queue_pkg.sv
// Shared register-file constants and the writeback entry type.
// Used by the register file, the decode stage and the writeback queue.
package writeback_queue_pkg;

  localparam int DATA_W    = 24;
  localparam int ADDR_W    = 4;
  localparam int NUM_REGS  = 16;
  localparam int WBQ_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file write port and lookup signals of the
// writeback queue.
interface writeback_queue_if
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] WriteD;
  logic [ADDR_W-1:0] q_rs;
  logic [ADDR_W-1:0] q_rt;
  logic              rs_pend;
  logic              rt_pend;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [CW-1:0]     count;
  logic              busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  q_rs, q_rt,
    output alu_ready, ld_ready,
    output RegWrite, Rd, WriteD,
    output rs_pend, rt_pend, rs_fwd, rt_fwd,
    output count, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output q_rs, q_rt,
    input  alu_ready, ld_ready,
    input  RegWrite, Rd, WriteD,
    input  rs_pend, rt_pend, rs_fwd, rt_fwd,
    input  count, busy
  );

endinterface

// File: rtl/writeback_queue_fifo.sv
// In-order writeback FIFO; per-entry valid bits and storage are
// exposed so the top level can search in-flight writes.
module wbq_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             entry_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [PW-1:0]         rptr_o,
  output wb_entry_t [DEPTH-1:0] ent_o,
  output logic [DEPTH-1:0]      vld_o
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH-1:0]      vld_q, vld_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (push_i) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_i) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d = rptr_q + 1'b1;
    end
    if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign rptr_o  = rptr_q;
  assign ent_o   = mem_q;
  assign vld_o   = vld_q;

endmodule

// File: rtl/writeback_queue.sv
// Two-producer writeback queue driving the register file write port,
// with a lookup over all not-yet-committed writes for forwarding.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  writeback_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                  full, push, pop;
  wb_entry_t             push_e, head;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         rptr, idx;
  wb_entry_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]      vld;

  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              rs_pend, rt_pend;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // Ready looks only at occupancy, never at the same-cycle pop.
  assign full   = (cnt == CW'(DEPTH));
  assign push   = (bus.alu_valid || bus.ld_valid) && !full;
  assign pop    = (cnt != '0);
  assign push_e = bus.alu_valid ? {bus.alu_rd, bus.alu_data}
                                : {bus.ld_rd, bus.ld_data};

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (push),
    .entry_i (push_e),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt),
    .rptr_o  (rptr),
    .ent_o   (ent),
    .vld_o   (vld)
  );

  always_comb begin
    rw_d = pop;
    rd_d = rd_q;
    wd_d = wd_q;
    if (pop) begin
      rd_d = head.rd;
      wd_d = head.data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rw_q <= 1'b0;
      rd_q <= '0;
      wd_q <= '0;
    end else begin
      rw_q <= rw_d;
      rd_q <= rd_d;
      wd_q <= wd_d;
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    rs_pend = 1'b0;
    rt_pend = 1'b0;
    rs_fwd  = '0;
    rt_fwd  = '0;
    idx     = '0;
    if (rw_q && rd_q == bus.q_rs) begin
      rs_pend = 1'b1;
      rs_fwd  = wd_q;
    end
    if (rw_q && rd_q == bus.q_rt) begin
      rt_pend = 1'b1;
      rt_fwd  = wd_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (vld[idx] && ent[idx].rd == bus.q_rs) begin
        rs_pend = 1'b1;
        rs_fwd  = ent[idx].data;
      end
      if (vld[idx] && ent[idx].rd == bus.q_rt) begin
        rt_pend = 1'b1;
        rt_fwd  = ent[idx].data;
      end
    end
  end

  assign bus.alu_ready = !full;
  assign bus.ld_ready  = !full && !bus.alu_valid;
  assign bus.RegWrite  = rw_q;
  assign bus.Rd        = rd_q;
  assign bus.WriteD    = wd_q;
  assign bus.rs_pend   = rs_pend;
  assign bus.rt_pend   = rt_pend;
  assign bus.rs_fwd    = rs_fwd;
  assign bus.rt_fwd    = rt_fwd;
  assign bus.count     = cnt;
  assign bus.busy      = pop || rw_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-based reference model compared on
// every negative edge, plus directed literal expectations.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = WBQ_DEPTH;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: queue of accepted results plus the write-port register.
  wb_entry_t   mq[$];
  bit          m_rw = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [23:0] m_wd = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_rw = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      bit        room, have;
      wb_entry_t e, h;
      room = (mq.size() < DEPTH);
      have = 1'b0;
      e    = '0;
      if (bus.alu_valid && room) begin
        e = {bus.alu_rd, bus.alu_data};
        have = 1'b1;
      end else if (bus.ld_valid && room) begin
        e = {bus.ld_rd, bus.ld_data};
        have = 1'b1;
      end
      if (mq.size() > 0) begin
        h = mq.pop_front();
        m_rw = 1'b1;
        m_rd = h.rd;
        m_wd = h.data;
      end else begin
        m_rw = 1'b0;
      end
      if (have) mq.push_back(e);
    end
  end

  function automatic void mlook(input logic [3:0] q, output logic p,
                                output logic [23:0] f);
    p = 1'b0;
    f = '0;
    if (m_rw && m_rd == q) begin
      p = 1'b1;
      f = m_wd;
    end
    foreach (mq[i]) begin
      if (mq[i].rd == q) begin
        p = 1'b1;
        f = mq[i].data;
      end
    end
  endfunction

  always @(negedge clock) begin
    logic        p;
    logic [23:0] f;
    logic        room;
    room = (mq.size() < DEPTH);
    chk("alu_ready", bus.alu_ready, room);
    chk("ld_ready", bus.ld_ready, room && !bus.alu_valid);
    chk("RegWrite", bus.RegWrite, m_rw);
    chk("Rd", bus.Rd, m_rd);
    chk("WriteD", bus.WriteD, m_wd);
    chk("count", bus.count, mq.size());
    chk("busy", bus.busy, (mq.size() != 0) || m_rw);
    mlook(bus.q_rs, p, f);
    chk("rs_pend", bus.rs_pend, p);
    chk("rs_fwd", bus.rs_fwd, f);
    mlook(bus.q_rt, p, f);
    chk("rt_pend", bus.rt_pend, p);
    chk("rt_fwd", bus.rt_fwd, f);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input bit v, input logic [3:0] rd,
                     input logic [23:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic ld(input bit v, input logic [3:0] rd,
                    input logic [23:0] d);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  initial begin
    bit av, lv, acc_a, acc_l;
    alu(0, 0, 0);
    ld(0, 0, 0);
    bus.q_rs = 0;
    bus.q_rt = 0;
    #12 reset = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_ready", bus.alu_ready, 1);

    // single ALU push
    cyc();
    alu(1, 3, 24'h00ABCD);
    bus.q_rs = 3;
    cyc();
    alu(0, 0, 0);
    chk("t1_pend_e1", bus.rs_pend, 1);
    chk("t1_regwrite_e1", bus.RegWrite, 0);
    cyc();
    chk("t1_regwrite_e2", bus.RegWrite, 1);
    chk("t1_rd_e2", bus.Rd, 3);
    chk("t1_wd_e2", bus.WriteD, 24'h00ABCD);
    chk("t1_fwd_e2", bus.rs_fwd, 24'h00ABCD);
    cyc();
    chk("t1_regwrite_e3", bus.RegWrite, 0);
    chk("t1_pend_e3", bus.rs_pend, 0);

    // ALU priority over load
    alu(1, 1, 24'h000011);
    ld(1, 2, 24'h000022);
    #1;
    chk("t2_ld_ready", bus.ld_ready, 0);
    cyc();
    alu(0, 0, 0);
    #1;
    chk("t2_ld_ready2", bus.ld_ready, 1);
    cyc();
    ld(0, 0, 0);
    chk("t2_rd_first", bus.Rd, 1);
    cyc();
    chk("t2_rd_second", bus.Rd, 2);
    chk("t2_wd_second", bus.WriteD, 24'h000022);
    cyc();
    chk("t2_idle", bus.RegWrite, 0);

    // forwarding of the youngest write
    bus.q_rs = 5;
    alu(1, 5, 24'h000001);
    cyc();
    alu(1, 5, 24'h000002);
    cyc();
    alu(0, 0, 0);
    chk("t3_fwd_both", bus.rs_fwd, 24'h000002);
    cyc();
    chk("t3_fwd_out", bus.rs_fwd, 24'h000002);
    chk("t3_pend_out", bus.rs_pend, 1);
    cyc();
    chk("t3_pend_done", bus.rs_pend, 0);
    chk("t3_fwd_done", bus.rs_fwd, 0);

    // pointer wrap, interleaved idle cycles
    for (int i = 1; i <= 10; i++) begin
      alu(1, 4'(i), 24'(i * 32'h111111));
      cyc();
      alu(0, 0, 0);
      if (i % 3 == 0) cyc();
    end
    repeat (3) cyc();

    // async reset while a write is on the port
    alu(1, 7, 24'h000007);
    cyc();
    alu(1, 8, 24'h000008);
    cyc();
    alu(0, 0, 0);
    chk("t5_pre_regwrite", bus.RegWrite, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_regwrite", bus.RegWrite, 0);
    chk("t5_wd", bus.WriteD, 0);
    chk("t5_rd", bus.Rd, 0);
    chk("t5_count", bus.count, 0);
    #3 reset = 1'b0;
    repeat (3) begin
      cyc();
      chk("t5_post_regwrite", bus.RegWrite, 0);
      chk("t5_post_busy", bus.busy, 0);
      chk("t5_post_ready", bus.alu_ready, 1);
    end

    // randomized producers holding offers until accepted
    av = 1'b0;
    lv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!av || acc_a) begin
        av = ($urandom_range(0, 99) < 55);
        alu(av, 4'($urandom_range(0, 15)), 24'($urandom));
      end
      if (!lv || acc_l) begin
        lv = ($urandom_range(0, 99) < 55);
        ld(lv, 4'($urandom_range(0, 15)), 24'($urandom));
      end
      bus.q_rs = 4'($urandom_range(0, 15));
      bus.q_rt = 4'($urandom_range(0, 15));
      #3;
      acc_a = av && bus.alu_ready;
      acc_l = lv && bus.ld_ready;
      cyc();
    end
    alu(0, 0, 0);
    ld(0, 0, 0);
    repeat (4) cyc();
    chk("end_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
